// File: rtl/udp_line_sched_if.sv
// Trigger/strobe bundle between the line scheduler, the dual-camera line buffer and the UDP engine.
// The master side is the scheduler; the slave side is the surrounding datapath.
interface udp_line_sched_if #(
  parameter int unsigned V_ACT = 720
);
  localparam int unsigned ROW_W = (V_ACT > 1) ? $clog2(V_ACT) : 1;

  logic             enable;
  logic             connected;
  logic             frame_start;
  logic             tx_re;
  logic             lb_error;
  logic             lb_trig;
  logic             udp_trig;
  logic             cam_id;
  logic [ROW_W-1:0] row;
  logic             busy;
  logic             frame_done;
  logic             frame_skip;
  logic             abort;

  modport master (
    input  enable, connected, frame_start, tx_re, lb_error,
    output lb_trig, udp_trig, cam_id, row, busy, frame_done, frame_skip, abort
  );

  modport slave (
    output enable, connected, frame_start, tx_re, lb_error,
    input  lb_trig, udp_trig, cam_id, row, busy, frame_done, frame_skip, abort
  );
endinterface

// File: rtl/udp_line_sched.sv
// Per-line sequencer: for every row and camera, triggers a line-buffer load, waits the fill time,
// starts a UDP packet, counts payload read strobes and spaces packets by an inter-packet gap.
module udp_line_sched #(
  parameter int unsigned V_ACT       = 720,
  parameter int unsigned LINE_BYTES  = 1280,
  parameter int unsigned FILL_CYCLES = 1400,
  parameter int unsigned IPG_CYCLES  = 64,
  parameter int unsigned TIMEOUT     = 4096
) (
  input logic              clk,
  input logic              rstn,
  udp_line_sched_if.master bus
);
  localparam int unsigned ROW_W    = (V_ACT > 1) ? $clog2(V_ACT) : 1;
  localparam int unsigned WAIT_MAX = (FILL_CYCLES > IPG_CYCLES) ? FILL_CYCLES : IPG_CYCLES;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int unsigned BYTE_W   = $clog2(LINE_BYTES + 1);
  localparam int unsigned TO_W     = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ARM, FILL, TRIG, SEND, GAP} state_t;

  state_t            state, state_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
  logic [BYTE_W-1:0] byte_cnt, byte_cnt_nx;
  logic [TO_W-1:0]   idle_cnt, idle_cnt_nx;
  logic [ROW_W-1:0]  row_q, row_nx;
  logic              cam_q, cam_nx;
  logic              stop_q, stop_nx;
  logic              stall;
  logic              frame_done_nx, frame_skip_nx, abort_nx;
  logic              lb_trig_q, udp_trig_q, busy_q, frame_done_q, frame_skip_q, abort_q;

  // Next-state and counter decode; abort overrides everything at the end.
  always_comb begin
    state_nx      = state;
    wait_cnt_nx   = wait_cnt;
    byte_cnt_nx   = byte_cnt;
    idle_cnt_nx   = idle_cnt;
    row_nx        = row_q;
    cam_nx        = cam_q;
    stop_nx       = stop_q;
    stall         = 1'b0;
    frame_done_nx = 1'b0;
    frame_skip_nx = 1'b0;
    abort_nx      = 1'b0;

    // enable dropping mid-frame is remembered so the current packet can drain first
    if (state != IDLE) begin
      frame_skip_nx = bus.frame_start;
      if (!bus.enable) stop_nx = 1'b1;
    end

    case (state)
      IDLE: begin
        if (bus.frame_start && bus.enable && bus.connected) begin
          state_nx = ARM;
          row_nx   = '0;
          cam_nx   = 1'b0;
        end
      end
      ARM: begin
        state_nx    = FILL;
        wait_cnt_nx = '0;
      end
      FILL: begin
        if (wait_cnt == WAIT_W'(FILL_CYCLES - 1)) begin
          state_nx    = TRIG;
          wait_cnt_nx = '0;
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
        end
      end
      TRIG: begin
        state_nx    = SEND;
        byte_cnt_nx = '0;
        idle_cnt_nx = '0;
      end
      SEND: begin
        if (bus.tx_re) begin
          idle_cnt_nx = '0;
          if (byte_cnt == BYTE_W'(LINE_BYTES - 1)) begin
            state_nx    = GAP;
            byte_cnt_nx = '0;
            wait_cnt_nx = '0;
          end else begin
            byte_cnt_nx = byte_cnt + 1'b1;
          end
        end else if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
          stall = 1'b1;
        end else begin
          idle_cnt_nx = idle_cnt + 1'b1;
        end
      end
      GAP: begin
        if (wait_cnt == WAIT_W'(IPG_CYCLES - 1)) begin
          wait_cnt_nx = '0;
          if (stop_nx) begin
            state_nx = IDLE;
          end else if (!cam_q) begin
            cam_nx   = 1'b1;
            state_nx = ARM;
          end else if (row_q < ROW_W'(V_ACT - 1)) begin
            cam_nx   = 1'b0;
            row_nx   = row_q + 1'b1;
            state_nx = ARM;
          end else begin
            frame_done_nx = 1'b1;
            state_nx      = IDLE;
          end
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if ((state != IDLE) && (!bus.connected || bus.lb_error || stall)) begin
      abort_nx      = 1'b1;
      frame_done_nx = 1'b0;
      state_nx      = IDLE;
      wait_cnt_nx   = '0;
      byte_cnt_nx   = '0;
      idle_cnt_nx   = '0;
    end

    // line index always restarts at (0,0) whenever the sequencer goes idle
    if (state_nx == IDLE) begin
      row_nx  = '0;
      cam_nx  = 1'b0;
      stop_nx = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      byte_cnt     <= '0;
      idle_cnt     <= '0;
      row_q        <= '0;
      cam_q        <= 1'b0;
      stop_q       <= 1'b0;
      lb_trig_q    <= 1'b0;
      udp_trig_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_skip_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state        <= state_nx;
      wait_cnt     <= wait_cnt_nx;
      byte_cnt     <= byte_cnt_nx;
      idle_cnt     <= idle_cnt_nx;
      row_q        <= row_nx;
      cam_q        <= cam_nx;
      stop_q       <= stop_nx;
      lb_trig_q    <= (state_nx == ARM);
      udp_trig_q   <= (state_nx == TRIG);
      busy_q       <= (state_nx != IDLE);
      frame_done_q <= frame_done_nx;
      frame_skip_q <= frame_skip_nx;
      abort_q      <= abort_nx;
    end
  end

  assign bus.lb_trig    = lb_trig_q;
  assign bus.udp_trig   = udp_trig_q;
  assign bus.cam_id     = cam_q;
  assign bus.row        = row_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_skip = frame_skip_q;
  assign bus.abort      = abort_q;
endmodule

// File: tb/tb_udp_line_sched.sv
// Scoreboard bench for udp_line_sched: a per-frame timeline planner predicts every pulse and level,
// a driver replays the planned inputs and a negedge monitor checks the DUT against the plan.
module tb_udp_line_sched;
  localparam int V_ACT = 2, LINE_BYTES = 4, FILL = 3, IPG = 2, TIMEOUT = 8, MAXC = 4096;
  localparam int K_LB = 0, K_UDP = 1, K_DONE = 2, K_SKIP = 3, K_ABORT = 4;
  localparam int M_NORM = 0, M_STALL = 1, M_ERR = 2, M_CONN = 3, M_EN = 4;

  typedef struct {
    int kind;
    int cyc;
    int row;
    int cam;
  } ev_t;

  logic clk;
  logic rstn;
  int   cyc;
  int   checks;
  int   errors;
  int   plan_hi;

  bit tx_plan [MAXC];
  bit fs_plan [MAXC];
  bit en_low  [MAXC];
  bit conn_low[MAXC];
  bit err_plan[MAXC];
  bit busy_exp[MAXC];
  bit rc_chk  [MAXC];
  int row_exp [MAXC];
  bit cam_exp [MAXC];
  ev_t sbq[$];

  udp_line_sched_if #(.V_ACT(V_ACT)) bus ();

  udp_line_sched #(
    .V_ACT(V_ACT), .LINE_BYTES(LINE_BYTES), .FILL_CYCLES(FILL),
    .IPG_CYCLES(IPG), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected events kept sorted by cycle, then by monitor scan order.
  function automatic void sb_push(input int kind, input int c, input int row, input int cam);
    ev_t e;
    int  idx;
    e.kind = kind; e.cyc = c; e.row = row; e.cam = cam;
    idx = sbq.size();
    for (int i = 0; i < sbq.size(); i++) begin
      if (sbq[i].cyc > c || (sbq[i].cyc == c && sbq[i].kind > kind)) begin
        idx = i;
        break;
      end
    end
    sbq.insert(idx, e);
  endfunction

  function automatic void mark(input int a, input int b, input int row, input int cam);
    for (int c = a; c <= b; c++) begin
      busy_exp[c] = 1'b1;
      rc_chk[c]   = 1'b1;
      row_exp[c]  = row;
      cam_exp[c]  = (cam != 0);
    end
  endfunction

  function automatic void rc0(input int c);
    rc_chk[c]  = 1'b1;
    row_exp[c] = 0;
    cam_exp[c] = 1'b0;
  endfunction

  // Lays out a whole frame from the line rules: ARM, FILL cycles, TRIG, strobes, gap.
  function automatic void plan_frame(input int s, input int mode, input int mline,
                                     input int maxgap, output int endc);
    int row, cam, t, u, c, last, e, nb, x;
    fs_plan[s] = 1'b1;
    t    = s + 1;
    endc = -1;
    last = 0;
    for (int i = 0; i < 2 * V_ACT && endc < 0; i++) begin
      row = i / 2;
      cam = i % 2;
      sb_push(K_LB, t, row, cam);
      u = t + FILL + 1;
      if (mode == M_ERR && i == mline) begin
        e = t + 1 + int'($urandom_range(0, FILL - 1));
        err_plan[e] = 1'b1;
        mark(t, e, row, cam);
        sb_push(K_ABORT, e + 1, 0, 0);
        rc0(e + 1);
        endc = e + 1;
      end else begin
        for (int k = t; k <= u; k++) if ($urandom_range(0, 3) == 0) tx_plan[k] = 1'b1;
        sb_push(K_UDP, u, row, cam);
        c  = u + 1;
        nb = (mode == M_STALL && i == mline) ? 2 : LINE_BYTES;
        for (int b = 0; b < nb; b++) begin
          c = c + int'($urandom_range(0, maxgap));
          tx_plan[c] = 1'b1;
          last = c;
          c++;
        end
        if (mode == M_STALL && i == mline) begin
          mark(t, last + TIMEOUT, row, cam);
          sb_push(K_ABORT, last + TIMEOUT + 1, 0, 0);
          rc0(last + TIMEOUT + 1);
          endc = last + TIMEOUT + 1;
        end else if (mode == M_CONN && i == mline) begin
          e = last + 1 + int'($urandom_range(0, IPG - 1));
          conn_low[e] = 1'b1;
          mark(t, e, row, cam);
          sb_push(K_ABORT, e + 1, 0, 0);
          rc0(e + 1);
          endc = e + 1;
        end else begin
          for (int k = 1; k <= IPG; k++) if ($urandom_range(0, 1) == 0) tx_plan[last + k] = 1'b1;
          mark(t, last + IPG, row, cam);
          t = last + IPG + 1;
          if (mode == M_EN && i == mline) begin
            x = int'($urandom_range(u + 1, last));
            for (int k = x; k <= t; k++) en_low[k] = 1'b1;
            endc = t;
          end
        end
      end
    end
    if (endc < 0) begin
      sb_push(K_DONE, t, 0, 0);
      rc0(t);
      endc = t;
    end
    plan_hi = endc + IPG + 2;
  endfunction

  function automatic int next_start();
    return ((plan_hi > cyc) ? plan_hi : cyc) + 3;
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    logic [7:0] v;
    v = {bus.lb_trig, bus.udp_trig, bus.cam_id, bus.row, bus.busy,
         bus.frame_done, bus.frame_skip, bus.abort};
    checks++;
    if (v !== 8'h00) begin
      errors++;
      $display("FAIL %s: outputs=%b required=00000000", name, v);
    end
  endtask

  task automatic run_frame(input int mode, input int mline, input int maxgap, input bit skip);
    int s, endc, k;
    s = next_start();
    plan_frame(s, mode, mline, maxgap, endc);
    if (skip) begin
      k = s + 1 + int'($urandom_range(0, endc - s - 2));
      fs_plan[k] = 1'b1;
      sb_push(K_SKIP, k + 1, row_exp[k + 1], int'(cam_exp[k + 1]));
    end
    wait_until(endc + 3);
  endtask

  // Driver: replays the planned inputs shortly after each rising edge.
  initial begin
    bus.frame_start = 1'b0;
    bus.tx_re       = 1'b0;
    bus.enable      = 1'b1;
    bus.connected   = 1'b1;
    bus.lb_error    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cyc < MAXC) begin
        bus.frame_start = fs_plan[cyc];
        bus.tx_re       = tx_plan[cyc];
        bus.enable      = !en_low[cyc];
        bus.connected   = !conn_low[cyc];
        bus.lb_error    = err_plan[cyc];
      end
    end
  end

  // Monitor: pops the scoreboard on every pulse and checks busy/row/cam levels each cycle.
  always @(negedge clk) begin
    bit [4:0] p;
    ev_t      e;
    p = {bus.abort, bus.frame_skip, bus.frame_done, bus.udp_trig, bus.lb_trig};
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event: kind=%0d due at cycle %0d not seen by cycle %0d", e.kind, e.cyc, cyc);
    end
    for (int k = 0; k < 5; k++) begin
      if (p[k]) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: kind=%0d at cycle %0d, required none", k, cyc);
        end else begin
          e = sbq.pop_front();
          if (e.kind != k || e.cyc != cyc || e.row != int'(bus.row) || e.cam != int'(bus.cam_id)) begin
            errors++;
            $display("FAIL event: got kind=%0d cyc=%0d row=%0d cam=%0d, required kind=%0d cyc=%0d row=%0d cam=%0d",
                     k, cyc, bus.row, bus.cam_id, e.kind, e.cyc, e.row, e.cam);
          end
        end
      end
    end
    if (cyc < MAXC) begin
      checks++;
      if (bus.busy !== busy_exp[cyc]) begin
        errors++;
        $display("FAIL busy: cycle %0d got %b required %b", cyc, bus.busy, busy_exp[cyc]);
      end
      if (rc_chk[cyc]) begin
        checks++;
        if (int'(bus.row) != row_exp[cyc] || bus.cam_id !== cam_exp[cyc]) begin
          errors++;
          $display("FAIL row_cam: cycle %0d got row=%0d cam=%b required row=%0d cam=%b",
                   cyc, bus.row, bus.cam_id, row_exp[cyc], cam_exp[cyc]);
        end
      end
    end
  end

  initial begin
    int s, endc, r;
    cyc     = 0;
    checks  = 0;
    errors  = 0;
    plan_hi = 0;
    rstn    = 1'b0;
    wait_until(3);
    #1 check_zero("reset_outputs");
    wait_until(4);
    #1 rstn = 1'b1;

    run_frame(M_NORM, 0, 0, 1'b0);
    run_frame(M_NORM, 0, 3, 1'b1);
    run_frame(M_NORM, 0, 3, 1'b1);
    run_frame(M_NORM, 0, 3, 1'b0);

    // frame_start while idle but link down, then while disabled: silently dropped
    s = next_start();
    fs_plan[s]     = 1'b1;
    conn_low[s]    = 1'b1;
    fs_plan[s + 3] = 1'b1;
    en_low[s + 3]  = 1'b1;
    plan_hi = s + 6;
    wait_until(s + 8);

    run_frame(M_STALL, int'($urandom_range(0, 2 * V_ACT - 1)), 3, 1'b0);
    run_frame(M_ERR, 2, 3, 1'b0);
    run_frame(M_CONN, int'($urandom_range(0, 2 * V_ACT - 1)), 3, 1'b0);
    run_frame(M_EN, 1, 3, 1'b0);
    run_frame(M_NORM, 0, 2, 1'b0);

    // reset asserted in the first SEND cycle of line (0,0)
    s = next_start();
    plan_frame(s, M_NORM, 0, 2, endc);
    r = s + FILL + 3;
    while (sbq.size() > 0 && sbq[sbq.size() - 1].cyc > r) void'(sbq.pop_back());
    for (int c = r + 1; c <= plan_hi; c++) begin
      tx_plan[c] = 1'b0; fs_plan[c] = 1'b0; en_low[c] = 1'b0; conn_low[c] = 1'b0;
      err_plan[c] = 1'b0; busy_exp[c] = 1'b0; rc_chk[c] = 1'b0;
    end
    wait_until(r);
    #1 rstn = 1'b0;
    #1 check_zero("async_reset_outputs");
    wait_until(r + 2);
    #1 rstn = 1'b1;

    run_frame(M_NORM, 0, 3, 1'b0);
    wait_until(cyc + 4);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d events left, required 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
